// File: rtl/c_wf_alloc_conn_lock_if.sv
// Connection-lock bundle between request logic, wavefront allocator and crossbar.
// master drives requests/grants/enable; slave (the lock block) drives masks and crossbar.
interface c_wf_alloc_conn_lock_if #(
   parameter int num_ports = 8
);
   logic                           active;
   logic [num_ports*num_ports-1:0] req_in;
   logic [num_ports-1:0]           valid_in;
   logic [num_ports-1:0]           tail_in;
   logic [num_ports*num_ports-1:0] req_alloc;
   logic [num_ports*num_ports-1:0] gnt_alloc;
   logic                           update;
   logic [num_ports*num_ports-1:0] xbar_sel;
   logic [num_ports-1:0]           xbar_valid;
   logic [num_ports*num_ports-1:0] lock_q;
   logic                           err;

   modport master (
      output active, req_in, valid_in, tail_in, gnt_alloc,
      input  req_alloc, update, xbar_sel, xbar_valid, lock_q, err
   );

   modport slave (
      input  active, req_in, valid_in, tail_in, gnt_alloc,
      output req_alloc, update, xbar_sel, xbar_valid, lock_q, err
   );
endinterface

// File: rtl/c_wf_alloc_conn_lock.sv
// Packet connection tracker: locks input->output pairs until tail, masks allocator requests.
// Ports: clk, reset (async, active-low), bus (slave: req/valid/tail/gnt in; req_alloc/update/xbar/lock/err out).
module c_wf_alloc_conn_lock #(
   parameter int num_ports  = 8,
   parameter bit err_sticky = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   c_wf_alloc_conn_lock_if.slave bus
);
   localparam int N  = num_ports;
   localparam int NN = N * N;

   logic [NN-1:0] lock_r, lock_nx;
   logic [NN-1:0] xsel_r, xsel_nx;
   logic [NN-1:0] req_m, gnt_new, conn;
   logic [N-1:0]  row_lk, col_lk, xfer;
   logic [N-1:0]  xval_r, xval_nx;
   logic [N-1:0]  rv, cv;
   logic          err_r, err_nx, err_now;

   // More than one bit set in v.
   function automatic logic multi(input logic [N-1:0] v);
      return |(v & (v - N'(1)));
   endfunction

   always_comb begin
      row_lk  = '0;
      col_lk  = '0;
      req_m   = '0;
      xfer    = '0;
      lock_nx = '0;
      xsel_nx = '0;
      xval_nx = '0;
      rv      = '0;
      cv      = '0;
      err_now = 1'b0;

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            row_lk[i] = row_lk[i] | lock_r[i*N+j];
            col_lk[j] = col_lk[j] | lock_r[i*N+j];
         end

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            req_m[i*N+j] = bus.req_in[i*N+j] & bus.valid_in[i]
                         & ~row_lk[i] & ~col_lk[j];

      // Grants outside the masked request set are dropped here.
      gnt_new = bus.gnt_alloc & req_m;
      conn    = lock_r | gnt_new;

      for (int i = 0; i < N; i++) begin
         rv      = conn[i*N +: N];
         xfer[i] = bus.valid_in[i] & (|rv);
         err_now = err_now | multi(rv) | multi(bus.req_in[i*N +: N]);
         for (int j = 0; j < N; j++) begin
            // A new grant always transfers, so ~xfer only holds existing locks.
            lock_nx[i*N+j] = conn[i*N+j] & (~xfer[i] | ~bus.tail_in[i]);
            xsel_nx[i*N+j] = conn[i*N+j] & xfer[i];
            xval_nx[j]     = xval_nx[j] | xsel_nx[i*N+j];
         end
      end

      for (int j = 0; j < N; j++) begin
         cv = '0;
         for (int i = 0; i < N; i++)
            cv[i] = conn[i*N+j];
         err_now = err_now | multi(cv);
      end

      err_now = err_now | (|(bus.gnt_alloc & ~req_m));
      err_nx  = err_sticky ? (err_r | err_now) : err_now;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_r <= '0;
         xsel_r <= '0;
         xval_r <= '0;
         err_r  <= 1'b0;
      end else if (bus.active) begin
         lock_r <= lock_nx;
         xsel_r <= xsel_nx;
         xval_r <= xval_nx;
         err_r  <= err_nx;
      end
   end

   assign bus.req_alloc  = req_m;
   assign bus.update     = |gnt_new;
   assign bus.xbar_sel   = xsel_r;
   assign bus.xbar_valid = xval_r;
   assign bus.lock_q     = lock_r;
   assign bus.err        = err_r;
endmodule
